// File: rtl/dft64_seq.sv
// Purpose: packs a 16-bit sample stream into 128-bit beats, issues one frame of beats to the DFT datapath, then times its done.
// Latency: start->sreset 1 cycle; lane-7 accept->rel 1 cycle; done->frame_ok 1 cycle; w==TIMEOUT without done->timeout_err 1 cycle.
// Backpressure: s_ready only in LOAD (dropped during the final rel cycle); s_valid low stalls packing with no penalty.
module dft64_seq #(
    parameter int SAMPLE_W = 16,
    parameter int LANES    = 8,
    parameter int BEATS    = 8,
    parameter int TIMEOUT  = 6
) (
    input  logic                      i_clk,
    input  logic                      i_reset_n,
    input  logic                      i_start,
    input  logic                      i_s_valid,
    input  logic [SAMPLE_W-1:0]       i_s_data,
    output logic                      o_s_ready,
    output logic                      o_dft_sreset,
    output logic [LANES*SAMPLE_W-1:0] o_dft_samples,
    output logic                      o_dft_rel,
    input  logic                      i_dft_done,
    output logic                      o_busy,
    output logic                      o_frame_ok,
    output logic                      o_timeout_err,
    output logic [7:0]                o_latency
);

    localparam int LW = $clog2(LANES);
    localparam int BW = $clog2(BEATS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CLR  = 2'd1,
        S_LOAD = 2'd2,
        S_WAIT = 2'd3
    } state_t;

    state_t                      r_state;
    logic [LW-1:0]               r_lane;
    logic [BW-1:0]               r_beat;
    logic [7:0]                  r_w;
    logic                        r_last;
    logic                        r_s_ready;
    logic                        r_dft_sreset;
    logic                        r_dft_rel;
    logic [LANES*SAMPLE_W-1:0]   r_dft_samples;
    logic                        r_frame_ok;
    logic                        r_timeout_err;
    logic [7:0]                  r_latency;
    logic [SAMPLE_W-1:0]         r_pack [LANES];

    logic                        w_accept;
    logic                        w_lane_last;
    logic                        w_beat_last;
    logic [LANES*SAMPLE_W-1:0]   w_beat;

    assign w_accept    = (r_state == S_LOAD) && r_s_ready && i_s_valid;
    assign w_lane_last = (r_lane == LW'(LANES - 1));
    assign w_beat_last = (r_beat == BW'(BEATS - 1));

    // Assemble the outgoing beat: lanes 0..LANES-2 from the pack register, the last lane straight from the input
    always_comb begin
        w_beat = '0;
        for (int i = 0; i < LANES; i++) begin
            if (i == LANES - 1) begin
                w_beat[(LANES-1-i)*SAMPLE_W +: SAMPLE_W] = i_s_data;
            end else begin
                w_beat[(LANES-1-i)*SAMPLE_W +: SAMPLE_W] = r_pack[i];
            end
        end
    end

    // Pack register: each accepted sample lands in its lane; stale lanes are always overwritten before reuse
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < LANES; i++) begin
                r_pack[i] <= '0;
            end
        end else if (w_accept) begin
            r_pack[r_lane] <= i_s_data;
        end
    end

    // Frame sequencer FSM with registered strobes, beat output register and done timer
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state       <= S_IDLE;
            r_lane        <= '0;
            r_beat        <= '0;
            r_w           <= '0;
            r_last        <= 1'b0;
            r_s_ready     <= 1'b0;
            r_dft_sreset  <= 1'b0;
            r_dft_rel     <= 1'b0;
            r_dft_samples <= '0;
            r_frame_ok    <= 1'b0;
            r_timeout_err <= 1'b0;
            r_latency     <= '0;
        end else begin
            r_dft_sreset  <= 1'b0;
            r_dft_rel     <= 1'b0;
            r_frame_ok    <= 1'b0;
            r_timeout_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state      <= S_CLR;
                        r_dft_sreset <= 1'b1;
                    end
                end
                S_CLR: begin
                    r_lane    <= '0;
                    r_beat    <= '0;
                    r_last    <= 1'b0;
                    r_s_ready <= 1'b1;
                    r_state   <= S_LOAD;
                end
                S_LOAD: begin
                    if (r_last) begin
                        // final rel cycle: ready already low, done ignored, move on to timing
                        r_last  <= 1'b0;
                        r_state <= S_WAIT;
                        r_w     <= 8'd1;
                    end else if (w_accept) begin
                        if (w_lane_last) begin
                            r_lane        <= '0;
                            r_dft_samples <= w_beat;
                            r_dft_rel     <= 1'b1;
                            if (w_beat_last) begin
                                r_beat    <= '0;
                                r_last    <= 1'b1;
                                r_s_ready <= 1'b0;
                            end else begin
                                r_beat <= r_beat + 1'b1;
                            end
                        end else begin
                            r_lane <= r_lane + 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    if (i_dft_done) begin
                        r_latency  <= r_w;
                        r_frame_ok <= 1'b1;
                        r_state    <= S_IDLE;
                    end else if (r_w == 8'(TIMEOUT)) begin
                        r_timeout_err <= 1'b1;
                        r_state       <= S_IDLE;
                    end else begin
                        r_w <= r_w + 8'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_s_ready     = r_s_ready;
    assign o_dft_sreset  = r_dft_sreset;
    assign o_dft_rel     = r_dft_rel;
    assign o_dft_samples = r_dft_samples;
    assign o_busy        = (r_state != S_IDLE);
    assign o_frame_ok    = r_frame_ok;
    assign o_timeout_err = r_timeout_err;
    assign o_latency     = r_latency;

endmodule

// File: tb/tb_dft64_seq.sv
// Bench for dft64_seq: table of frame scenarios plus randomized frames, checked against a frame-level model.
// Beats are predicted from the sample list; outcome/latency/end cycle from the done delay vs the timeout window.
// Cycle counting is relative to the edge that samples start (cycle 1 = CLR).
module tb_dft64_seq;

    logic         clk = 1'b0;
    logic         i_reset_n;
    logic         i_start;
    logic         i_s_valid;
    logic [15:0]  i_s_data;
    logic         i_dft_done;
    logic         o_s_ready;
    logic         o_dft_sreset;
    logic [127:0] o_dft_samples;
    logic         o_dft_rel;
    logic         o_busy;
    logic         o_frame_ok;
    logic         o_timeout_err;
    logic [7:0]   o_latency;

    always #5 clk = ~clk;

    dft64_seq dut (
        .i_clk         (clk),
        .i_reset_n     (i_reset_n),
        .i_start       (i_start),
        .i_s_valid     (i_s_valid),
        .i_s_data      (i_s_data),
        .o_s_ready     (o_s_ready),
        .o_dft_sreset  (o_dft_sreset),
        .o_dft_samples (o_dft_samples),
        .o_dft_rel     (o_dft_rel),
        .i_dft_done    (i_dft_done),
        .o_busy        (o_busy),
        .o_frame_ok    (o_frame_ok),
        .o_timeout_err (o_timeout_err),
        .o_latency     (o_latency)
    );

    int checks = 0;
    int errors = 0;
    logic [15:0] smp [64];
    int lat_model = 0;

    typedef struct {
        string name;
        int    stall;    // 0 none, >0 valid low every Nth cycle, <0 random
        int    done_d;   // WAIT cycle in which done is driven, 0 = never
        bit    sil;      // pulse start during LOAD
        bit    dil;      // drive done throughout LOAD incl. last rel cycle
        bit    exp_ok;
        int    exp_lat;
        int    exp_off;  // cycles from last rel to the result pulse
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] all_out();
        return {114'd0, o_s_ready, o_dft_sreset, o_dft_rel, o_dft_samples,
                o_busy, o_frame_ok, o_timeout_err, o_latency};
    endfunction

    task automatic fill_sine();
        for (int n = 0; n < 64; n++) begin
            smp[n] = 16'(int'(256.0 * $sin(2.0 * 3.14159265358979 * n / 48.0)));
        end
    endtask

    task automatic fill_random();
        for (int n = 0; n < 64; n++) begin
            smp[n] = 16'($urandom);
        end
    endtask

    // Frame-level outcome model: done inside the window wins, otherwise a timeout after the full window
    task automatic model_outcome(input int d, output bit ok, output int lat, output int off);
        ok  = (d >= 1) && (d <= 6);
        lat = ok ? d : lat_model;
        off = ok ? d + 1 : 7;
    endtask

    // Starts a frame in the current cycle (caller sits #1 after a rising edge) and checks it to completion
    task automatic run_frame(input string tag, input int stall, input int done_d, input bit sil, input bit dil,
                             input int abort_beats, input bit exp_ok, input int exp_lat, input int exp_off);
        int cyc;
        int idx;
        int nrel;
        int last_rel;
        int first_rdy;
        int rel_cyc [8];
        bit fin;
        bit aborted;
        bit start_sent;
        bit v;
        bit spacing_ok;
        logic [127:0] exp_beat;

        i_start    = 1'b1;
        i_s_valid  = 1'b0;
        i_dft_done = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_clr"}, {o_dft_sreset, o_busy, o_s_ready, o_frame_ok, o_timeout_err}, 5'b11000);

        cyc = 1; idx = 0; nrel = 0; last_rel = -1; first_rdy = -1;
        fin = 0; aborted = 0; start_sent = 0;
        while (!fin) begin
            // drive this cycle
            if (stall == 0)     v = 1'b1;
            else if (stall > 0) v = ((cyc % stall) != (stall - 1));
            else                v = ($urandom_range(0, 3) != 0);
            i_s_valid = v && (idx < 64);
            if (i_s_valid) i_s_data = smp[idx];
            else           i_s_data = 16'($urandom);
            i_start = sil && (nrel == 3) && !start_sent;
            if (i_start) start_sent = 1;
            i_dft_done = (dil && ((nrel < 8) || (cyc == last_rel))) ||
                         ((last_rel >= 0) && (done_d > 0) && (cyc == last_rel + done_d));
            if (i_s_valid && o_s_ready) idx++;

            @(posedge clk); #1;
            cyc++;

            // observe this cycle
            if (o_s_ready && first_rdy < 0) first_rdy = cyc;
            if (o_dft_rel) begin
                nrel++;
                if (nrel <= 8) begin
                    exp_beat = '0;
                    for (int j = 0; j < 8; j++) exp_beat[127-16*j -: 16] = smp[8*(nrel-1)+j];
                    chk($sformatf("%s_beat%0d", tag, nrel - 1), o_dft_samples, exp_beat);
                    rel_cyc[nrel-1] = cyc;
                end
                if (nrel == 8) begin
                    last_rel = cyc;
                    chk({tag, "_last_rel_ready"}, o_s_ready, 1'b0);
                end
                if (abort_beats > 0 && nrel == abort_beats) begin
                    i_reset_n  = 1'b0;
                    i_s_valid  = 1'b0;
                    i_start    = 1'b0;
                    i_dft_done = 1'b0;
                    #1;
                    chk({tag, "_abort_outputs"}, all_out(), 256'd0);
                    aborted = 1;
                    fin     = 1;
                end
            end
            if (!aborted && (o_frame_ok || o_timeout_err)) begin
                fin = 1;
                chk({tag, "_outcome"}, {o_frame_ok, o_timeout_err}, {exp_ok, !exp_ok});
                chk({tag, "_end_offset"}, cyc - last_rel, exp_off);
                chk({tag, "_latency"}, o_latency, exp_lat);
                chk({tag, "_busy_end"}, o_busy, 1'b0);
                chk({tag, "_rel_count"}, nrel, 8);
                chk({tag, "_first_ready"}, first_rdy, 2);
                if (stall == 0) begin
                    spacing_ok = 1;
                    for (int k = 0; k < 8; k++) if (rel_cyc[k] != 10 + 8 * k) spacing_ok = 0;
                    chk({tag, "_rel_spacing"}, spacing_ok, 1'b1);
                    chk({tag, "_last_rel_cycle"}, last_rel, 66);
                end
            end
            if (!fin && cyc >= 600) begin
                chk({tag, "_frame_budget"}, cyc, 0);
                fin = 1;
            end
        end
        i_start    = 1'b0;
        i_s_valid  = 1'b0;
        i_dft_done = 1'b0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int lat;
        int off;
        int d;

        i_reset_n  = 1'b0;
        i_start    = 1'b0;
        i_s_valid  = 1'b0;
        i_s_data   = '0;
        i_dft_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", all_out(), 256'd0);
        i_reset_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            chk($sformatf("idle_%0d", c), all_out(), 256'd0);
        end

        tbl[0] = '{"nominal",      0, 3, 1'b0, 1'b0, 1'b1, 3, 4};
        tbl[1] = '{"stall3",       3, 3, 1'b0, 1'b0, 1'b1, 3, 4};
        tbl[2] = '{"timeout",      0, 0, 1'b0, 1'b0, 1'b0, 3, 7};
        tbl[3] = '{"done_w6",      0, 6, 1'b0, 1'b0, 1'b1, 6, 7};
        tbl[4] = '{"done_w7",      0, 7, 1'b0, 1'b0, 1'b0, 6, 7};
        tbl[5] = '{"load_events",  0, 1, 1'b1, 1'b1, 1'b1, 1, 2};
        tbl[6] = '{"stall_start",  3, 2, 1'b1, 1'b0, 1'b1, 2, 3};

        fill_sine();
        for (int i = 0; i < 7; i++) begin
            if (i == 5) fill_random();
            run_frame(tbl[i].name, tbl[i].stall, tbl[i].done_d, tbl[i].sil, tbl[i].dil, 0,
                      tbl[i].exp_ok, tbl[i].exp_lat, tbl[i].exp_off);
            lat_model = tbl[i].exp_lat;
        end

        // reset after 3 beats, then a fresh frame with new samples
        fill_random();
        run_frame("abort", 0, 3, 1'b0, 1'b0, 3, 1'b1, 3, 4);
        repeat (2) @(posedge clk);
        #1;
        chk("abort_held", all_out(), 256'd0);
        i_reset_n = 1'b1;
        lat_model = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk($sformatf("post_abort_%0d", c), {o_busy, o_frame_ok, o_timeout_err, o_dft_rel, o_s_ready, o_latency}, 13'd0);
        end
        fill_random();
        run_frame("fresh", 0, 4, 1'b0, 1'b0, 0, 1'b1, 4, 5);
        lat_model = 4;

        for (int r = 0; r < 6; r++) begin
            fill_random();
            d = $urandom_range(1, 8);
            model_outcome(d, ok, lat, off);
            run_frame($sformatf("rand%0d", r), -1, d, 1'b0, 1'b0, 0, ok, lat, off);
            lat_model = lat;
        end

        @(posedge clk); #1;
        chk("final_idle", {o_busy, o_frame_ok, o_timeout_err, o_dft_rel}, 4'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
